// File: rtl/cla_seq_divider.sv
// cla_seq_divider: sequential restoring unsigned divider.
// Each CALC cycle shifts one dividend bit into the partial remainder. It then
// runs one trial subtraction R - D through a WIDTH+1-bit carry-lookahead chain
// (R + ~D + 1). The trial is kept only when the chain reports no borrow.
module cla_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  // The extra trial bit keeps the shifted partial remainder from overflowing.
  localparam int TW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;        // latched divisor
  logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_q, r_d;        // partial remainder (always < divisor)
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [TW-1:0]    trial_a;
  logic [TW:0]      trial;           // {carry_out, difference}
  logic             no_borrow;
  logic [WIDTH-1:0] r_next, q_next;
  logic             unused_trial_msb;

  // Carry-lookahead adder: every carry is a flat sum of generate terms
  // qualified by the propagate run above them, rather than a rippled chain.
  function automatic logic [TW:0] cla_add(input logic [TW-1:0] a,
                                          input logic [TW-1:0] b,
                                          input logic          cin);
    logic [TW-1:0] g, p;
    logic [TW:0]   c;
    logic          pp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < TW; i++) begin
      pp = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & cin);
    end
    return {c[TW], p ^ c[TW-1:0]};
  endfunction

  // One restoring step: shift, trial-subtract, keep the difference if no borrow.
  always_comb begin
    trial_a          = {r_q, q_q[WIDTH-1]};
    trial            = cla_add(trial_a, ~{1'b0, d_q}, 1'b1);
    no_borrow        = trial[TW];
    r_next           = no_borrow ? trial[WIDTH-1:0] : trial_a[WIDTH-1:0];
    q_next           = {q_q[WIDTH-2:0], no_borrow};
    // When the trial is kept its top bit is always zero, so it is never read.
    unused_trial_msb = trial[TW-1];
  end

  // State and datapath registers; async reset returns everything to zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      d_q     <= '0;
      q_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      q_q     <= q_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: accept start in IDLE/DONE, iterate WIDTH times in CALC.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    q_d     = q_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          if (divisor_i != '0) begin
            state_d = CALC;
            d_d     = divisor_i;
            q_d     = dividend_i;
            r_d     = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
          end else begin
            // Divide by zero finishes at once, without a CALC phase.
            state_d = DONE;
            quot_d  = '1;
            rem_d   = dividend_i;
            dbz_d   = 1'b1;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      CALC: begin
        q_d   = q_next;
        r_d   = r_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          quot_d  = q_next;
          rem_d   = r_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o        = (state_q == CALC);
  assign done_o        = (state_q == DONE);
  assign quotient_o    = quot_q;
  assign remainder_o   = rem_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_cla_seq_divider.sv
// Directed and exhaustive bench for cla_seq_divider (WIDTH=4) with a result scoreboard.
module tb_cla_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dividend, divisor;
  logic       busy, done, dbz;
  logic [3:0] quotient, remainder;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       z;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  cla_seq_divider #(.WIDTH(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .dividend_i    (dividend),
    .divisor_i     (divisor),
    .busy_o        (busy),
    .done_o        (done),
    .quotient_o    (quotient),
    .remainder_o   (remainder),
    .div_by_zero_o (dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q = 4'hF; e.r = a; e.z = 1'b1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0;
    end
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s scoreboard empty observed=%0h expected=entry", tag, quotient);
    end else begin
      checks--;
      e = sb.pop_front();
      chk({tag, ".q"}, quotient, e.q);
      chk({tag, ".r"}, remainder, e.r);
      chk({tag, ".dbz"}, dbz, e.z);
    end
  endtask

  // Called right after a negedge. Drives one op, waits (bounded) for done,
  // and returns the edge count from the accepting edge and busy cycles seen.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit hold,
                        output int edges, output int busy_cnt);
    push_exp(a, b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    edges    = 0;
    busy_cnt = 0;
    @(posedge clk);
    edges++;
    #1 if (!hold) start = 1'b0;
    @(negedge clk);
    if (busy) busy_cnt++;
    while (!done && edges < 30) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    int edges, bc;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.q", quotient, 4'd0);
    chk("rst.r", remainder, 4'd0);
    chk("rst.dbz", dbz, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 1: 13/4, latency and busy window
    run_op(4'd13, 4'd4, 1'b0, edges, bc);
    chk("t1.done", done, 1'b1);
    chk("t1.lat", edges, 5);
    chk("t1.busy", bc, 4);
    pop_check("t1");
    @(negedge clk);
    chk("t1.pulse", done, 1'b0);

    // 2: boundary operands
    run_op(4'd15, 4'd1, 1'b0, edges, bc);
    chk("t2a.lat", edges, 5);
    pop_check("t2a");
    @(negedge clk);
    run_op(4'd3, 4'd15, 1'b0, edges, bc);
    chk("t2b.lat", edges, 5);
    pop_check("t2b");
    @(negedge clk);

    // 3: divide by zero
    run_op(4'd7, 4'd0, 1'b0, edges, bc);
    chk("t3.lat", edges, 1);
    chk("t3.busy", bc, 0);
    pop_check("t3");
    @(negedge clk);
    chk("t3.pulse", done, 1'b0);

    // 4: start while busy is ignored
    push_exp(4'd9, 4'd2);
    dividend = 4'd9; divisor = 4'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 begin start = 1'b1; dividend = 4'd15; divisor = 4'd3; end
    @(posedge clk); #1 start = 1'b0;
    edges = 3;
    @(negedge clk);
    while (!done && edges < 30) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    chk("t4.lat", edges, 5);
    pop_check("t4");
    repeat (3) begin
      @(negedge clk);
      chk("t4.nodone", done, 1'b0);
    end
    chk("t4.idle", busy, 1'b0);

    // 5: reset during the second CALC cycle
    dividend = 4'd13; divisor = 4'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("t5.busy", busy, 1'b0);
    chk("t5.done", done, 1'b0);
    chk("t5.q", quotient, 4'd0);
    chk("t5.r", remainder, 4'd0);
    chk("t5.dbz", dbz, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("t5.nodone", done, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("t5.nodone2", done, 1'b0);
    run_op(4'd10, 4'd3, 1'b0, edges, bc);
    chk("t5.lat", edges, 5);
    pop_check("t5");
    @(negedge clk);

    // 6: exhaustive sweep with start held for back-to-back ops
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(4'(a), 4'(b), 1'b1, edges, bc);
        chk($sformatf("t6.lat.%0d/%0d", a, b), edges, (b == 0) ? 1 : 5);
        pop_check($sformatf("t6.%0d/%0d", a, b));
      end
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t6.idle", done, 1'b0);
    chk("t6.sb", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
